// File: rtl/nms_pkg.sv
// Shared encodings for the non-maximum suppression core: gradient direction codes
// and the sequencing FSM states.
package nms_pkg;

   localparam logic [1:0] DIR_0   = 2'd0;
   localparam logic [1:0] DIR_45  = 2'd1;
   localparam logic [1:0] DIR_90  = 2'd2;
   localparam logic [1:0] DIR_135 = 2'd3;

   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } nms_state_e;

endpackage

// File: rtl/nms_dir_compare.sv
// Directional keep test for a 3x3 magnitude window ([row][col], row 0 = north, col 0 = west).
// The centre survives when it is >= the first neighbour and > the second neighbour on its axis.
module nms_dir_compare
   import nms_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [2:0][2:0][DATA_WIDTH-1:0] win_i,
   input  logic [1:0]                      dir_i,
   output logic                            keep_o
);

   logic [DATA_WIDTH-1:0] c, a, b;

   always_comb begin
      c = win_i[1][1];
      a = win_i[1][0];
      b = win_i[1][2];
      case (dir_i)
         DIR_45: begin
            a = win_i[0][2];
            b = win_i[2][0];
         end
         DIR_90: begin
            a = win_i[0][1];
            b = win_i[2][1];
         end
         DIR_135: begin
            a = win_i[0][0];
            b = win_i[2][2];
         end
         default: begin
            a = win_i[1][0];
            b = win_i[1][2];
         end
      endcase
      keep_o = (c >= a) && (c > b);
   end

endmodule

// File: rtl/nms_suppress_3x3.sv
// Non-maximum suppression over a 3x3 window fed by a 3-row line buffer; emits one pixel per
// frame position in raster order with borders zeroed. Optional low threshold: NMS_THRESH_EN.
module nms_suppress_3x3
   import nms_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int LINE_WIDTH   = 1920,
   parameter int FRAME_HEIGHT = 1080,
   parameter int THRESH       = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] row_0,
   input  logic [DATA_WIDTH-1:0] row_1,
   input  logic [DATA_WIDTH-1:0] row_2,
   input  logic [1:0]            dir_in,
   output logic [DATA_WIDTH-1:0] mag_out,
   output logic                  out_valid,
   output logic                  sof_out
);

   localparam int XW = $clog2(LINE_WIDTH);
   localparam int YW = $clog2(FRAME_HEIGHT);
   localparam int FW = $clog2(LINE_WIDTH + 2);
   localparam logic [XW-1:0] X_LAST = XW'(LINE_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);
   localparam logic [FW-1:0] F_LAST = FW'(LINE_WIDTH);
`ifdef NMS_THRESH_EN
   localparam logic [DATA_WIDTH-1:0] THRESH_V = DATA_WIDTH'(THRESH);
`endif

   nms_state_e                       state_q, state_d;
   logic [XW-1:0]                    x_q, x_d;
   logic [YW-1:0]                    y_q, y_d;
   logic [FW-1:0]                    f_q, f_d;
   // Only columns 1..2 are stored; column 0 of the next window is the old column 1.
   logic [2:0][2:1][DATA_WIDTH-1:0]  win_q, win_d;
   logic [2:0][2:0][DATA_WIDTH-1:0]  win_sh;
   logic [1:0]                       dir_q, dir_d;
   logic [DATA_WIDTH-1:0]            mag_q, mag_d;
   logic                             vld_q, vld_d, sof_q, sof_d;
   logic                             accept, keep, keep_ok, border;
   logic [XW-1:0]                    cx;
   logic [YW-1:0]                    cy;

   assign in_ready  = (state_q != ST_FLUSH);
   assign accept    = enable && in_ready;
   assign mag_out   = mag_q;
   assign out_valid = vld_q;
   assign sof_out   = sof_q;

   // The compare sees the window as it will be after this accept, so the result lands with it.
   assign win_sh[0] = {row_0, win_q[0][2], win_q[0][1]};
   assign win_sh[1] = {row_1, win_q[1][2], win_q[1][1]};
   assign win_sh[2] = {row_2, win_q[2][2], win_q[2][1]};

   nms_dir_compare #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
      .win_i  (win_sh),
      .dir_i  (dir_q),
      .keep_o (keep)
   );

`ifdef NMS_THRESH_EN
   assign keep_ok = keep && (win_sh[1][1] >= THRESH_V);
`else
   assign keep_ok = keep;
`endif

   // Centre trails the input by one line plus one pixel.
   assign cx     = (x_q == '0) ? X_LAST : x_q - XW'(1);
   assign cy     = (x_q == '0) ? y_q - YW'(2) : y_q - YW'(1);
   assign border = (cx == '0) || (cx == X_LAST) || (cy == '0) || (cy == Y_LAST);

   always_comb begin
      win_d = win_q;
      dir_d = dir_q;
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[r][1] = win_sh[r][1];
            win_d[r][2] = win_sh[r][2];
         end
         dir_d = dir_in;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      f_d     = f_q;
      mag_d   = '0;
      vld_d   = 1'b0;
      sof_d   = 1'b0;
      if (accept) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
         end else begin
            x_d = x_q + XW'(1);
         end
      end
      case (state_q)
         ST_PRIME: begin
            if (accept && (x_q == '0) && (y_q == YW'(1))) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (accept) begin
               vld_d = 1'b1;
               mag_d = (!border && keep_ok) ? win_sh[1][1] : '0;
               sof_d = (cx == '0) && (cy == '0);
               if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                  x_d     = x_q;
                  y_d     = y_q;
                  state_d = ST_FLUSH;
               end
            end
         end
         ST_FLUSH: begin
            vld_d = 1'b1;
            if (f_q == F_LAST) begin
               f_d     = '0;
               x_d     = '0;
               y_d     = '0;
               state_d = ST_PRIME;
            end else begin
               f_d = f_q + FW'(1);
            end
         end
         default: state_d = ST_PRIME;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_PRIME;
         x_q     <= '0;
         y_q     <= '0;
         f_q     <= '0;
         win_q   <= '0;
         dir_q   <= DIR_0;
         mag_q   <= '0;
         vld_q   <= 1'b0;
         sof_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         f_q     <= f_d;
         win_q   <= win_d;
         dir_q   <= dir_d;
         mag_q   <= mag_d;
         vld_q   <= vld_d;
         sof_q   <= sof_d;
      end
   end

endmodule
